// File: rtl/trigger_capture.sv
// Triggered single-shot capture of a display sample stream into a DEPTH-entry buffer.
// Arms on enable, waits for a level crossing (or auto timeout), fills the buffer, then holds until rearm.
module trigger_capture #(
  parameter int DEPTH   = 640,
  parameter int AW      = 10,
  parameter int AUTO_TO = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic [7:0]    sample_in,
  input  logic          sample_valid,
  input  logic [7:0]    trig_level,
  input  logic          trig_edge,
  input  logic          auto_mode,
  input  logic          rearm,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          busy,
  output logic          done,
  output logic          forced
);

  localparam int TW = $clog2(AUTO_TO + 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(AUTO_TO - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_TRIG = 2'd1,
    S_CAPTURE   = 2'd2,
    S_HOLD      = 2'd3
  } state_t;

  state_t          state_reg, state_next;
  logic [7:0]      prev_reg, prev_next;
  logic            prev_loaded_reg, prev_loaded_next;
  logic [TW-1:0]   tmo_reg, tmo_next;
  logic [AW-1:0]   wr_ptr_reg, wr_ptr_next;
  logic            forced_reg, forced_next;
  logic            done_reg, done_next;
  logic [7:0]      rd_data_reg;

  logic            wr_req;
  logic            mem_we;
  logic [AW-1:0]   wr_addr;
  logic [7:0]      mem [DEPTH];

  logic            rise_hit;
  logic            fall_hit;
  logic            edge_hit;
  logic            timeout_hit;

  // The very first sample after arming has no valid predecessor, so it can never be an edge.
  assign rise_hit    = (prev_reg < trig_level) && (sample_in >= trig_level);
  assign fall_hit    = (prev_reg > trig_level) && (sample_in <= trig_level);
  assign edge_hit    = prev_loaded_reg && (trig_edge ? fall_hit : rise_hit);
  assign timeout_hit = auto_mode && (tmo_reg == TMO_LAST);

  always_comb begin
    state_next       = state_reg;
    prev_next        = prev_reg;
    prev_loaded_next = prev_loaded_reg;
    tmo_next         = tmo_reg;
    wr_ptr_next      = wr_ptr_reg;
    forced_next      = forced_reg;
    done_next        = 1'b0;
    wr_req           = 1'b0;
    wr_addr          = wr_ptr_reg;

    if (!enable) begin
      state_next = S_IDLE;
    end else begin
      unique case (state_reg)
        S_IDLE: begin
          state_next       = S_WAIT_TRIG;
          tmo_next         = '0;
          prev_loaded_next = 1'b0;
        end

        S_WAIT_TRIG: begin
          if (sample_valid) begin
            prev_next        = sample_in;
            prev_loaded_next = 1'b1;
            // Saturate so a late switch to auto mode forces promptly instead of wrapping.
            if (tmo_reg != TMO_LAST) begin
              tmo_next = tmo_reg + TW'(1);
            end
            if (edge_hit || timeout_hit) begin
              forced_next = ~edge_hit;
              wr_req      = 1'b1;
              wr_addr     = '0;
              wr_ptr_next = AW'(1);
              state_next  = S_CAPTURE;
            end
          end
        end

        S_CAPTURE: begin
          if (sample_valid) begin
            wr_req  = 1'b1;
            wr_addr = wr_ptr_reg;
            if (wr_ptr_reg == LAST_ADDR) begin
              state_next = S_HOLD;
              done_next  = 1'b1;
            end else begin
              wr_ptr_next = wr_ptr_reg + AW'(1);
            end
          end
        end

        S_HOLD: begin
          if (rearm) begin
            state_next       = S_WAIT_TRIG;
            tmo_next         = '0;
            prev_loaded_next = 1'b0;
          end
        end

        default: state_next = S_IDLE;
      endcase
    end
  end

  // Reset must cut off the write in the same cycle it is asserted.
  assign mem_we = wr_req & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= S_IDLE;
      prev_reg        <= '0;
      prev_loaded_reg <= 1'b0;
      tmo_reg         <= '0;
      wr_ptr_reg      <= '0;
      forced_reg      <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      prev_reg        <= prev_next;
      prev_loaded_reg <= prev_loaded_next;
      tmo_reg         <= tmo_next;
      wr_ptr_reg      <= wr_ptr_next;
      forced_reg      <= forced_next;
      done_reg        <= done_next;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_addr] <= sample_in;
    end
  end

  // Separate read process keeps read-before-write behaviour on address collisions.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_reg <= '0;
    end else begin
      rd_data_reg <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_reg;
  assign busy    = (state_reg == S_WAIT_TRIG) || (state_reg == S_CAPTURE);
  assign done    = done_reg;
  assign forced  = forced_reg;

endmodule

// File: tb/tb_trigger_capture.sv
// Self-checking bench for trigger_capture: table-driven capture scenarios, hand-written
// hold/rearm/abort sequences and randomized traffic, all checked against a behavioural model.
module tb_trigger_capture;

  localparam int DEPTH   = 640;
  localparam int AW      = 10;
  localparam int AUTO_TO = 1024;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [7:0]    sample_in;
  logic          sample_valid;
  logic [7:0]    trig_level;
  logic          trig_edge;
  logic          auto_mode;
  logic          rearm;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          busy;
  logic          done;
  logic          forced;

  always #5 clk = ~clk;

  trigger_capture #(.DEPTH(DEPTH), .AW(AW), .AUTO_TO(AUTO_TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .trig_level   (trig_level),
    .trig_edge    (trig_edge),
    .auto_mode    (auto_mode),
    .rearm        (rearm),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .busy         (busy),
    .done         (done),
    .forced       (forced)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check_rng(input string name, input int got, input int lo, input int hi);
    total++;
    if (got < lo || got > hi) begin
      bad++;
      $display("FAIL %s: got=%0d expected in [%0d,%0d]", name, got, lo, hi);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef enum int {M_OFF, M_ARMED, M_FILL, M_FROZEN} mphase_t;
  mphase_t m_phase = M_OFF;
  int      m_seen  = 0;     // valid samples seen since arming
  int      m_last  = 0;     // previous valid sample while armed
  int      m_fill  = 0;     // samples stored in the current capture
  bit      m_forced = 0;
  bit      m_done   = 0;
  int      m_rd     = 0;
  bit      m_rd_chk = 0;
  int      m_mem   [DEPTH];
  bit      m_known [DEPTH];
  int      cycle = 0;
  int      trig_cycle = 0;
  int      done_count = 0;

  // stimulus generator controls
  int stim_kind = 0;        // 0 none, 1 ramp, 2 constant, 3 random
  int period    = 1;
  int ramp_val  = 0;
  int const_val = 0;
  int cyc_cnt   = 0;

  task automatic model_store(input int a, input int v);
    m_mem[a]   = v;
    m_known[a] = 1'b1;
  endtask

  task automatic model_step();
    int  s;
    int  lvl;
    bit  hit_e;
    bit  hit_t;
    s      = int'(sample_in);
    lvl    = int'(trig_level);
    m_done = 1'b0;
    if (rst) begin
      m_phase  = M_OFF;
      m_forced = 1'b0;
      m_rd     = 0;
      m_rd_chk = 1'b1;
      return;
    end
    m_rd_chk = (int'(rd_addr) < DEPTH) && m_known[int'(rd_addr) % DEPTH];
    if (m_rd_chk) m_rd = m_mem[int'(rd_addr)];
    if (!enable) begin
      m_phase = M_OFF;
      return;
    end
    case (m_phase)
      M_OFF: begin
        m_phase = M_ARMED;
        m_seen  = 0;
      end
      M_ARMED: if (sample_valid) begin
        m_seen++;
        if (trig_edge) hit_e = (m_seen > 1) && (m_last > lvl) && (s <= lvl);
        else           hit_e = (m_seen > 1) && (m_last < lvl) && (s >= lvl);
        hit_t  = auto_mode && (m_seen >= AUTO_TO);
        m_last = s;
        if (hit_e || hit_t) begin
          model_store(0, s);
          m_fill     = 1;
          m_forced   = !hit_e;
          m_phase    = M_FILL;
          trig_cycle = cycle;
        end
      end
      M_FILL: if (sample_valid) begin
        model_store(m_fill, s);
        m_fill++;
        if (m_fill == DEPTH) begin
          m_phase = M_FROZEN;
          m_done  = 1'b1;
        end
      end
      M_FROZEN: if (rearm) begin
        m_phase = M_ARMED;
        m_seen  = 0;
      end
      default: m_phase = M_OFF;
    endcase
  endtask

  // One clock: generate the sample, advance the model, let the DUT take the edge, compare.
  task automatic tick();
    bit v;
    cyc_cnt++;
    case (stim_kind)
      1, 2:    v = (cyc_cnt % period) == 0;
      3:       v = $urandom_range(0, 1) == 1;
      default: v = 1'b0;
    endcase
    sample_valid = v;
    if (v && stim_kind == 1) begin
      sample_in = 8'(ramp_val);
      ramp_val  = (ramp_val + 1) % 256;
    end else if (v && stim_kind == 2) begin
      sample_in = 8'(const_val);
    end else if (stim_kind == 3) begin
      sample_in = 8'($urandom_range(0, 255));
    end else begin
      sample_in = 8'hEE;
    end
    model_step();
    @(posedge clk);
    #1;
    cycle++;
    if (done) done_count++;
    check("busy", int'(busy), int'(m_phase == M_ARMED || m_phase == M_FILL));
    check("done", int'(done), int'(m_done));
    check("forced", int'(forced), int'(m_forced));
    if (m_rd_chk) check("rd_data", int'(rd_data), m_rd);
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; rearm = 1'b0; rd_addr = '0; stim_kind = 0;
    tick();
    tick();
    check("reset_rd_data", int'(rd_data), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_forced", int'(forced), 0);
    rst = 1'b0;
  endtask

  task automatic wait_fill(input int n, input string name);
    int w;
    w = 0;
    while (!(m_phase == M_FILL && m_fill == n) && w < 4000) begin
      tick();
      w++;
    end
    if (w >= 4000) check({name, "_timeout"}, 0, 1);
  endtask

  // ---------------- scenario table ----------------
  typedef struct {
    bit edge_sel;
    bit autom;
    int level;
    int kind;
    int cval;
    int per;
    int exp0;
    int explast;
    bit expforced;
    int lat_min;
    int lat_max;
  } case_t;

  case_t cases [4];
  int    snap [DEPTH];

  task automatic run_case(input int idx);
    case_t c;
    int    waited;
    int    done_cycle;
    int    got0;
    int    gotlast;
    c = cases[idx];
    do_reset();
    trig_edge  = c.edge_sel;
    auto_mode  = c.autom;
    trig_level = 8'(c.level);
    period     = c.per;
    const_val  = c.cval;
    ramp_val   = 0;
    cyc_cnt    = 0;
    done_count = 0;
    enable     = 1'b1;
    tick();
    stim_kind  = c.kind;
    waited     = 0;
    done_cycle = -1;
    while (waited < 6000 && done_cycle < 0) begin
      tick();
      waited++;
      if (done) done_cycle = cycle;
    end
    if (done_cycle < 0) check($sformatf("case%0d_done_timeout", idx), 0, 1);
    else check_rng($sformatf("case%0d_latency", idx), done_cycle - trig_cycle, c.lat_min, c.lat_max);
    check($sformatf("case%0d_forced", idx), int'(forced), int'(c.expforced));
    for (int i = 0; i < 20; i++) tick();
    got0 = 0;
    gotlast = 0;
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = AW'(a);
      tick();
      if (a == 0) got0 = int'(rd_data);
      if (a == DEPTH - 1) gotlast = int'(rd_data);
    end
    check($sformatf("case%0d_addr0", idx), got0, c.exp0);
    check($sformatf("case%0d_addr_last", idx), gotlast, c.explast);
    check($sformatf("case%0d_done_pulses", idx), done_count, 1);
    $display("case %0d: edge=%0d auto=%0d per=%0d addr0=%0d last=%0d forced=%0d", idx,
             c.edge_sel, c.autom, c.per, got0, gotlast, forced);
  endtask

  initial begin
    int dc0;
    rst = 1'b1; enable = 1'b0; sample_in = '0; sample_valid = 1'b0;
    trig_level = 8'h80; trig_edge = 1'b0; auto_mode = 1'b0; rearm = 1'b0; rd_addr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = 0;
      m_known[i] = 1'b0;
    end

    //            edge auto level kind cval per exp0   last   frc lat_min lat_max
    cases[0] = '{1'b0, 1'b0, 8'h80, 1, 0,    1, 8'h80, 8'hFF, 1'b0, 638, 642};
    cases[1] = '{1'b1, 1'b0, 8'h80, 1, 0,    1, 8'h00, 8'h7F, 1'b0, 638, 642};
    cases[2] = '{1'b0, 1'b1, 8'h80, 2, 8'h10, 1, 8'h10, 8'h10, 1'b1, 638, 642};
    cases[3] = '{1'b0, 1'b0, 8'h80, 1, 0,    3, 8'h80, 8'hFF, 1'b0, 1910, 1925};

    for (int k = 1; k < 4; k++) run_case(k);
    run_case(0);

    // Hold with ramp still running, then rearm; a second rearm while busy is ignored.
    rearm = 1'b1; tick(); rearm = 1'b0;
    check("rearm_busy", int'(busy), 1);
    rearm = 1'b1; tick(); rearm = 1'b0;
    check("second_rearm_busy", int'(busy), 1);
    check("second_rearm_done", int'(done), 0);
    $display("rearm: busy=%0d", busy);

    // Abort by enable at write pointer 300.
    snap = m_mem;
    dc0 = done_count;
    wait_fill(300, "abort_en");
    enable = 1'b0;
    tick();
    check("abort_en_busy", int'(busy), 0);
    for (int i = 0; i < 10; i++) tick();
    check("abort_en_no_done", done_count - dc0, 0);
    for (int a = 300; a < DEPTH; a++) begin
      rd_addr = AW'(a);
      tick();
      check($sformatf("abort_en_keep%0d", a), int'(rd_data), snap[a]);
    end
    $display("abort by enable: done pulses=%0d", done_count - dc0);

    // Abort by reset at write pointer 300, with enable still high.
    enable = 1'b1;
    tick();
    snap = m_mem;
    dc0 = done_count;
    wait_fill(300, "abort_rst");
    rst = 1'b1;
    tick();
    check("abort_rst_busy", int'(busy), 0);
    check("abort_rst_rd_data", int'(rd_data), 0);
    rst = 1'b0; enable = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("abort_rst_no_done", done_count - dc0, 0);
    for (int a = 300; a < DEPTH; a++) begin
      rd_addr = AW'(a);
      tick();
      check($sformatf("abort_rst_keep%0d", a), int'(rd_data), snap[a]);
    end
    $display("abort by reset: done pulses=%0d", done_count - dc0);

    // Randomized traffic against the model.
    for (int seg = 0; seg < 3; seg++) begin
      do_reset();
      trig_level = 8'($urandom_range(0, 255));
      trig_edge  = $urandom_range(0, 1) == 1;
      auto_mode  = (seg != 1);
      stim_kind  = 3;
      enable     = 1'b1;
      dc0        = done_count;
      for (int i = 0; i < 5000; i++) begin
        rearm   = $urandom_range(0, 19) == 0;
        enable  = $urandom_range(0, 599) != 0;
        rst     = $urandom_range(0, 2499) == 0;
        rd_addr = AW'($urandom_range(0, DEPTH + 40));
        tick();
      end
      rst = 1'b0; rearm = 1'b0;
      $display("random seg %0d: level=%0d edge=%0d captures=%0d", seg, trig_level, trig_edge,
               done_count - dc0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
